formula_result_buffer: RTL and testbench

- Output-side receiver for the non-stallable formula pipeline (a**5 + 0.3*b - c). The arithmetic wrappers cannot be back-pressured, so this block absorbs results and re-presents them on an AXI-Stream-style res_vld/res_rdy interface.
- It reserves one storage slot per accepted argument set. From those reservations it generates the upstream arg_rdy credit, so no result is ever dropped when the consumer stalls.
- It sits between the pipeline's final down_valid/res and the system consumer.

---
 rtl/formula_stream_pkg.sv | 14 +
 rtl/formula_credit_ctr.sv | 54 +++++
 rtl/formula_result_buffer.sv | 91 +++++++++
 tb/tb_formula_result_buffer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/formula_stream_pkg.sv
// Shared types and sizing helpers for the formula pipeline's output stream.
package formula_stream_pkg;

    localparam int FLEN          = 32;
    localparam int DEFAULT_DEPTH = 16;

    typedef logic [FLEN-1:0] flt_t;

    // Width needed to count 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/formula_credit_ctr.sv
// Credit and in-flight bookkeeping: one credit per free slot that is not yet
// reserved by an argument set still travelling through the pipeline.
module formula_credit_ctr
    import formula_stream_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic clk,
    input  logic rst,
    input  logic issue,
    input  logic pop,
    input  logic result,
    output logic arg_rdy,
    output logic unreserved
);

    localparam int CNT_W = cnt_w(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CREDIT = CNT_W'(DEPTH);

    logic [CNT_W-1:0] credits_reg;
    logic [CNT_W-1:0] credits_next;
    logic [CNT_W-1:0] inflight_reg;
    logic [CNT_W-1:0] inflight_next;
    logic             result_taken;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credits_reg  <= FULL_CREDIT;
            inflight_reg <= '0;
        end else begin
            credits_reg  <= credits_next;
            inflight_reg <= inflight_next;
        end
    end

    // Both counters saturate so unreserved results can never wrap them.
    always_comb begin
        result_taken  = result && (inflight_reg != '0);
        credits_next  = credits_reg;
        inflight_next = inflight_reg;
        if (issue && !pop && credits_reg != '0)
            credits_next = credits_reg - CNT_W'(1);
        else if (pop && !issue && credits_reg != FULL_CREDIT)
            credits_next = credits_reg + CNT_W'(1);
        if (issue && !result_taken)
            inflight_next = inflight_reg + CNT_W'(1);
        else if (!issue && result_taken)
            inflight_next = inflight_reg - CNT_W'(1);
    end

    assign arg_rdy    = (credits_reg != '0);
    assign unreserved = result && (inflight_reg == '0);

endmodule

// File: rtl/formula_result_buffer.sv
// Absorbs results from the non-stallable formula pipeline and re-presents them
// on a valid/ready stream, issuing upstream credit only for reserved slots.
module formula_result_buffer
    import formula_stream_pkg::*;
#(
    parameter int FLEN  = 32,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       arg_vld,
    output logic                       arg_rdy,
    input  logic                       pipe_vld,
    input  logic [FLEN-1:0]            pipe_res,
    output logic                       res_vld,
    input  logic                       res_rdy,
    output logic [FLEN-1:0]            res,
    output logic [cnt_w(DEPTH)-1:0]    occupancy,
    output logic                       overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);
    localparam logic [CNT_W-1:0] FULL_OCC = CNT_W'(DEPTH);

    logic [FLEN-1:0]  storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] occ_reg;
    logic [CNT_W-1:0] occ_next;
    logic             overflow_reg;
    logic             issue;
    logic             pop;
    logic             full;
    logic             wr_en;
    logic             unreserved;

    assign issue = arg_vld && arg_rdy;
    assign pop   = res_vld && res_rdy;
    assign full  = (occ_reg == FULL_OCC);
    // A pop frees the head slot before the write lands, so full+pop still writes.
    assign wr_en = pipe_vld && (!full || pop);

    formula_credit_ctr #(
        .DEPTH      (DEPTH)
    ) u_credit (
        .clk        (clk),
        .rst        (rst),
        .issue      (issue),
        .pop        (pop),
        .result     (pipe_vld),
        .arg_rdy    (arg_rdy),
        .unreserved (unreserved)
    );

    always_ff @(posedge clk) begin
        if (wr_en)
            storage[wr_ptr_reg] <= pipe_res;
    end

    always_comb begin
        occ_next = occ_reg;
        if (wr_en && !pop)
            occ_next = occ_reg + CNT_W'(1);
        else if (!wr_en && pop)
            occ_next = occ_reg - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            occ_reg      <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            occ_reg <= occ_next;
            if (pipe_vld && (unreserved || !wr_en))
                overflow_reg <= 1'b1;
        end
    end

    assign res_vld   = (occ_reg != '0);
    assign res       = res_vld ? storage[rd_ptr_reg] : '0;
    assign occupancy = occ_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_formula_result_buffer.sv
// Drives a latency-LAT pipeline model into the result buffer and compares every
// output each cycle against a queue-based reference of the stream behaviour.
module tb_formula_result_buffer;

    localparam int DEPTH = 16;
    localparam int LAT   = 12;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk      = 1'b0;
    logic             rst      = 1'b0;
    logic             arg_vld  = 1'b0;
    logic             arg_rdy;
    logic             pipe_vld = 1'b0;
    logic [31:0]      pipe_res = '0;
    logic             res_vld;
    logic             res_rdy  = 1'b0;
    logic [31:0]      res;
    logic [CNT_W-1:0] occupancy;
    logic             overflow;

    typedef struct {
        int          due;
        logic [31:0] val;
    } pend_t;

    pend_t       pipe_q[$];
    logic [31:0] m_q[$];
    int          m_cred;
    int          m_infl;
    bit          m_ovf;
    int          cyc;
    int          n_issued;
    int          n_cmp;
    int          n_err;
    int          rdy_low;
    logic [31:0] next_val;
    string       phase;

    always #5 clk = ~clk;

    formula_result_buffer #(
        .FLEN      (32),
        .DEPTH     (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .arg_vld   (arg_vld),
        .arg_rdy   (arg_rdy),
        .pipe_vld  (pipe_vld),
        .pipe_res  (pipe_res),
        .res_vld   (res_vld),
        .res_rdy   (res_rdy),
        .res       (res),
        .occupancy (occupancy),
        .overflow  (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s/%s at cycle %0d: observed %h expected %h", phase, tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] exp_res;
        exp_res = (m_q.size() != 0) ? m_q[0] : 32'h0;
        check("arg_rdy",   32'(arg_rdy),   32'(m_cred != 0));
        check("res_vld",   32'(res_vld),   32'(m_q.size() != 0));
        check("res",       res,            exp_res);
        check("occupancy", 32'(occupancy), m_q.size());
        check("overflow",  32'(overflow),  32'(m_ovf));
    endtask

    task automatic model_reset();
        m_q.delete();
        pipe_q.delete();
        m_cred = DEPTH;
        m_infl = 0;
        m_ovf  = 1'b0;
    endtask

    // One clock: inputs driven at posedge+1, model advanced, outputs checked.
    task automatic run_cycle(input logic av, input logic rr, input logic inj, input logic [31:0] inj_val);
        logic        pv;
        logic [31:0] pr;
        logic [31:0] popped;
        bit          issue;
        bit          pop;
        bit          wr;
        bit          ovf_now;
        pv = 1'b0;
        pr = '0;
        popped = '0;
        if (pipe_q.size() != 0 && pipe_q[0].due <= cyc) begin
            pv = 1'b1;
            pr = pipe_q[0].val;
            void'(pipe_q.pop_front());
        end else if (inj) begin
            pv = 1'b1;
            pr = inj_val;
        end
        arg_vld  = av;
        res_rdy  = rr;
        pipe_vld = pv;
        pipe_res = pr;
        issue   = av && (m_cred != 0);
        pop     = rr && (m_q.size() != 0);
        ovf_now = pv && (m_infl == 0 || (m_q.size() == DEPTH && !pop));
        wr      = pv && (m_q.size() < DEPTH || pop);
        if (issue) begin
            pipe_q.push_back('{cyc + LAT, next_val});
            n_issued++;
        end
        @(posedge clk);
        #1;
        if (pop) popped = m_q.pop_front();
        if (wr) m_q.push_back(pr);
        if (ovf_now) m_ovf = 1'b1;
        if (issue && !pop) m_cred--;
        else if (pop && !issue && m_cred < DEPTH) m_cred++;
        m_infl = m_infl + (issue ? 1 : 0) - ((pv && m_infl > 0) ? 1 : 0);
        if (pop) $display("[%0t] %s pop res=%h occ=%0d", $time, phase, popped, m_q.size());
        cyc++;
        check_all();
    endtask

    task automatic drain(input int bound);
        int k;
        k = 0;
        while ((m_q.size() != 0 || pipe_q.size() != 0) && k < bound) begin
            run_cycle(1'b0, 1'b1, 1'b0, '0);
            k++;
        end
        check("drain_done", 32'(k < bound), 32'h1);
    endtask

    task automatic async_reset();
        arg_vld  = 1'b0;
        pipe_vld = 1'b0;
        res_rdy  = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("rst_res_vld",   32'(res_vld),   32'h0);
        check("rst_occupancy", 32'(occupancy), 32'h0);
        check("rst_res",       res,            32'h0);
        check("rst_overflow",  32'(overflow),  32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        check_all();
    endtask

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0; n_issued = 0; rdy_low = 0;
        next_val = '0;
        model_reset();

        phase = "reset_idle";
        repeat (3) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        check_all();
        repeat (3) run_cycle(1'b0, 1'b0, 1'b0, '0);

        phase = "fill";
        n_issued = 0;
        for (int i = 0; i < DEPTH + LAT + 2; i++) begin
            next_val = 32'h3F80_0000 + 32'(n_issued);
            run_cycle(1'b1, 1'b0, 1'b0, '0);
        end
        check("full_arg_rdy",   32'(arg_rdy),   32'h0);
        check("full_occupancy", 32'(occupancy), 32'(DEPTH));
        check("full_head",      res,            32'h3F80_0000);

        phase = "pop_issue";
        run_cycle(1'b0, 1'b1, 1'b0, '0);
        check("after_pop_rdy", 32'(arg_rdy), 32'h1);
        next_val = 32'h3F80_1000;
        run_cycle(1'b1, 1'b1, 1'b0, '0);
        next_val = 32'h3F80_2000;
        run_cycle(1'b1, 1'b0, 1'b0, '0);
        drain(200);

        phase = "stream";
        for (int i = 0; i < 1000; i++) begin
            next_val = $urandom;
            run_cycle(1'b1, 1'b1, 1'b0, '0);
            if (arg_rdy !== 1'b1) rdy_low++;
        end
        check("stream_rdy_low", 32'(rdy_low), 32'h0);
        phase = "random";
        for (int i = 0; i < 400; i++) begin
            next_val = $urandom;
            run_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, '0);
        end
        drain(300);

        phase = "unreserved";
        run_cycle(1'b0, 1'b0, 1'b1, 32'h4000_0000);
        check("unres_overflow", 32'(overflow), 32'h1);
        check("unres_res",      res,           32'h4000_0000);
        run_cycle(1'b0, 1'b1, 1'b0, '0);
        repeat (3) run_cycle(1'b1, 1'b0, 1'b0, '0);
        drain(100);

        phase = "mid_reset";
        for (int i = 0; i < 5; i++) begin
            next_val = $urandom;
            run_cycle(1'b1, 1'b0, 1'b0, '0);
        end
        for (int i = 0; i < LAT + 1; i++) run_cycle(1'b0, 1'b0, 1'b0, '0);
        check("pre_reset_occ", 32'(occupancy), 32'h5);
        async_reset();

        phase = "drop_full";
        for (int i = 0; i < DEPTH + LAT + 2; i++) begin
            next_val = $urandom;
            run_cycle(1'b1, 1'b0, 1'b0, '0);
        end
        run_cycle(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        run_cycle(1'b0, 1'b1, 1'b1, 32'hCAFE_F00D);
        drain(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
